// File: rtl/fence_sequencer.sv
// fence_sequencer: sequences D$ flush (with ack handshake and timeout),
// I$ flush, TLB flush and the commit-PC redirect for FENCE, FENCE.I and
// SFENCE.VMA. Requests arriving while busy are merged into a pending set
// and serviced after the current sequence returns to IDLE.
// Build option: define FENCE_SEQ_WT_DCACHE_EN for a write-through D$ core;
// the D$ flush stage, its wait counter and timeout_o are then removed.
module fence_sequencer #(
  parameter int TimeoutCycles = 1024,
  parameter int CntWidth      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fence_req_i,
  input  logic fence_i_req_i,
  input  logic sfence_vma_req_i,
  input  logic dcache_flush_ack_i,
  output logic flush_dcache_o,
  output logic flush_icache_o,
  output logic flush_tlb_o,
  output logic set_pc_commit_o,
  output logic halt_o,
  output logic busy_o,
  output logic timeout_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLUSH_D   = 3'd1,
    FLUSH_I   = 3'd2,
    FLUSH_TLB = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t     state, state_next;
  // Kind vectors are ordered {need_d, need_i, need_tlb}.
  logic [2:0] kind, kind_next;
  logic [2:0] pend, pend_next;
  // pend_any is needed because a write-through fence carries no stage bits
  // yet must still produce a redirect.
  logic       pend_any, pend_any_next;
  logic [2:0] req_kind;
  logic       req_any;
  logic [2:0] uni;
  logic       uni_any;
  logic       ack_hit;
  logic       timeout_hit;

  // First stage still needed by a kind vector, in order D, I, TLB.
  function automatic state_t first_stage(input logic [2:0] k);
    if (k[2])      return FLUSH_D;
    else if (k[1]) return FLUSH_I;
    else if (k[0]) return FLUSH_TLB;
    else           return DONE;
  endfunction

  assign req_any = fence_req_i | fence_i_req_i | sfence_vma_req_i;
  assign uni     = req_kind | pend;
  assign uni_any = req_any | pend_any;

`ifdef FENCE_SEQ_WT_DCACHE_EN
  // Write-through D$: nothing to write back, so need_d is never requested.
  localparam int unused_timeout_cfg = TimeoutCycles + CntWidth;
  logic unused_ack;
  assign unused_ack     = dcache_flush_ack_i;
  assign req_kind       = {1'b0, fence_i_req_i, sfence_vma_req_i};
  assign ack_hit        = 1'b0;
  assign timeout_hit    = 1'b0;
  assign flush_dcache_o = 1'b0;
  assign timeout_o      = 1'b0;
`else
  localparam logic [CntWidth-1:0] CntLast =
    CntWidth'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);

  logic [CntWidth-1:0] cnt;
  logic                timeout_q;

  assign req_kind       = {fence_req_i | fence_i_req_i, fence_i_req_i, sfence_vma_req_i};
  assign ack_hit        = (state == FLUSH_D) && dcache_flush_ack_i;
  // An ack on the last allowed cycle wins over the timeout.
  assign timeout_hit    = (state == FLUSH_D) && !dcache_flush_ack_i &&
                          (TimeoutCycles > 0) && (cnt == CntLast);
  assign flush_dcache_o = (state == FLUSH_D);
  assign timeout_o      = timeout_q;

  // Ack wait counter: zero on entry to FLUSH_D, counts each cycle there.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               cnt <= '0;
    else if (state == FLUSH_D) cnt <= cnt + CntWidth'(1);
    else                       cnt <= '0;
  end

  // Timeout pulse appears the cycle after the wait expires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timeout_q <= 1'b0;
    else         timeout_q <= timeout_hit;
  end
`endif

  // State, latched kind and pending-request registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      kind     <= '0;
      pend     <= '0;
      pend_any <= 1'b0;
    end else begin
      state    <= state_next;
      kind     <= kind_next;
      pend     <= pend_next;
      pend_any <= pend_any_next;
    end
  end

  // Next-state logic; requests seen outside IDLE are merged into pending.
  always_comb begin
    state_next    = state;
    kind_next     = kind;
    pend_next     = pend;
    pend_any_next = pend_any;
    case (state)
      IDLE: begin
        pend_next     = '0;
        pend_any_next = 1'b0;
        if (uni_any) begin
          kind_next  = uni;
          state_next = first_stage(uni);
        end
      end
      FLUSH_D: begin
        if (ack_hit || timeout_hit) state_next = first_stage({1'b0, kind[1:0]});
      end
      FLUSH_I:   state_next = first_stage({2'b00, kind[0]});
      FLUSH_TLB: state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (state != IDLE) begin
      pend_next     = pend | req_kind;
      pend_any_next = pend_any | req_any;
    end
  end

  assign flush_icache_o  = (state == FLUSH_I);
  assign flush_tlb_o     = (state == FLUSH_TLB);
  assign set_pc_commit_o = (state == DONE);
  assign busy_o          = (state != IDLE);
  assign halt_o          = busy_o;

endmodule

// File: tb/tb_fence_sequencer.sv
// Testbench for fence_sequencer: directed scenarios followed by random
// request/ack traffic, checked every cycle against a schedule-based model.
module tb_fence_sequencer;

  localparam int TO = 6;

  logic clk;
  logic rst_ni;
  logic fence_req, fence_i_req, sfence_req, dack;
  logic flush_d, flush_i, flush_t, set_pc, halt, busy, tmo;

  fence_sequencer #(.TimeoutCycles(TO)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .fence_req_i        (fence_req),
    .fence_i_req_i      (fence_i_req),
    .sfence_vma_req_i   (sfence_req),
    .dcache_flush_ack_i (dack),
    .flush_dcache_o     (flush_d),
    .flush_icache_o     (flush_i),
    .flush_tlb_o        (flush_t),
    .set_pc_commit_o    (set_pc),
    .halt_o             (halt),
    .busy_o             (busy),
    .timeout_o          (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle of output activity, plus whether the bench drives ack.
  typedef struct packed {
    logic d, i, t, pc, halt, to, ack;
  } ent_t;

  ent_t       sched[$];
  logic [2:0] pend;
  logic       pend_any;
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input logic d, i, t, pc, to, ack);
    ent_t e;
    e = '{d: d, i: i, t: t, pc: pc, halt: 1'b1, to: to, ack: ack};
    sched.push_back(e);
  endtask

  // Build the whole cycle schedule of one sequence. ackpos 1..TO: ack on that
  // D$ cycle; ackpos 0: no ack, so the wait runs TO cycles and times out.
  task automatic launch(input logic [2:0] k, input int ackpos);
    logic to_pend;
    int   n;
    to_pend = 1'b0;
    if (k[2]) begin
      n = (ackpos == 0) ? TO : ackpos;
      for (int c = 1; c <= n; c++)
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (ackpos != 0) && (c == n));
      to_pend = (ackpos == 0);
    end
    if (k[1]) begin push(1'b0, 1'b1, 1'b0, 1'b0, to_pend, 1'b0); to_pend = 1'b0; end
    if (k[0]) begin push(1'b0, 1'b0, 1'b1, 1'b0, to_pend, 1'b0); to_pend = 1'b0; end
    push(1'b0, 1'b0, 1'b0, 1'b1, to_pend, 1'b0);
  endtask

  task automatic check_all(input ent_t e);
    chk("flush_dcache", flush_d, e.d);
    chk("flush_icache", flush_i, e.i);
    chk("flush_tlb",    flush_t, e.t);
    chk("set_pc",       set_pc,  e.pc);
    chk("halt",         halt,    e.halt);
    chk("busy",         busy,    e.halt);
    chk("timeout",      tmo,     e.to);
  endtask

  // One clock cycle: drive requests, check outputs, advance the model.
  task automatic step(input logic f, input logic fi, input logic sv, input int ackpos);
    ent_t       e;
    logic       idle;
    logic [2:0] k;
    logic       any;
    idle = (sched.size() == 0);
    e    = idle ? ent_t'(0) : sched[0];
    fence_req   = f;
    fence_i_req = fi;
    sfence_req  = sv;
    if (!idle && e.d) dack = e.ack;
    else              dack = ($urandom_range(0, 3) == 0);
    #1;
    check_all(e);
    if (!idle) void'(sched.pop_front());
`ifdef FENCE_SEQ_WT_DCACHE_EN
    k = {1'b0, fi, sv};
`else
    k = {f | fi, fi, sv};
`endif
    any = f | fi | sv;
    if (idle) begin
      if (any || pend_any) launch(k | pend, ackpos);
      pend     = '0;
      pend_any = 1'b0;
    end else begin
      pend     = pend | k;
      pend_any = pend_any | any;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    ent_t z;
    z           = '0;
    pend        = '0;
    pend_any    = 1'b0;
    fence_req   = 1'b0;
    fence_i_req = 1'b0;
    sfence_req  = 1'b0;
    dack        = 1'b0;
    rst_ni      = 1'b0;
    #2;
    check_all(z);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // fence, ack on 5th D$ cycle
    step(1'b1, 1'b0, 1'b0, 5);
    idle_steps(8);
    // fence.i, ack on 2nd D$ cycle
    step(1'b0, 1'b1, 1'b0, 2);
    idle_steps(6);
    // fence + sfence.vma together, ack immediately
    step(1'b1, 1'b0, 1'b1, 1);
    idle_steps(5);
    // fence with lost ack -> timeout
    step(1'b1, 1'b0, 1'b0, 0);
    idle_steps(10);
    // ack on the final allowed cycle: counts as ack, no timeout
    step(1'b1, 1'b0, 1'b0, TO);
    idle_steps(10);
    // sfence.vma arriving while the fence waits for ack
    step(1'b1, 1'b0, 1'b0, 4);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    idle_steps(12);

    // asynchronous reset while in FLUSH_D with a pending request
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    rst_ni = 1'b0;
    #1;
    check_all(z);
    sched.delete();
    pend     = '0;
    pend_any = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    idle_steps(10);

    // random traffic, requests sometimes landing while busy
    for (int n = 0; n < 500; n++)
      step($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 11) == 0, int'($urandom_range(0, TO)));
    idle_steps(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
